// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with early-out divide cases
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic            is_div, a_signed, b_signed, sa, sb;
  logic            div_zero, div_ovf, early, accept;
  logic [XLEN-1:0] mag_a, mag_b, early_res;

  always_comb begin
    is_div    = op[2];
    a_signed  = is_div ? ~op[0] : (op == 3'b001 || op == 3'b010);
    b_signed  = is_div ? ~op[0] : (op == 3'b001);
    sa        = a_signed & a[XLEN-1];
    sb        = b_signed & b[XLEN-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
    div_zero  = is_div && (b == '0);
    div_ovf   = is_div && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    early     = div_zero | div_ovf;
    if (div_zero) early_res = op[1] ? a : '1;
    else          early_res = op[1] ? '0 : a;
    accept    = reset && !flush && start && (state_q == IDLE || state_q == DONE);
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  logic [2*XLEN-1:0] step_acc;
  logic [XLEN:0]     sum, rem_ext, diff;

  always_comb begin
    step_acc = acc_q;
    sum      = '0;
    rem_ext  = '0;
    diff     = '0;
    for (int u = 0; u < UNROLL; u++) begin
      if (!op_q[2]) begin
        sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opnd_q} : '0);
        step_acc = {sum, step_acc[XLEN-1:1]};
      end else begin
        rem_ext = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
        diff    = rem_ext - {1'b0, opnd_q};
        if (!diff[XLEN]) step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
        else             step_acc = {rem_ext[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) fix_res = op_q[1] ? rem : quot;
    else         fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d  = DONE;
        result_d = fix_res;
        rd_out_d = rd_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (accept) begin
      op_d    = op;
      rd_d    = rd_in;
      neg_a_d = sa;
      neg_b_d = sb;
      opnd_d  = mag_b;
      acc_d   = {{XLEN{1'b0}}, mag_a};
      cnt_d   = '0;
      if (early) begin
        state_d  = DONE;
        result_d = early_res;
        rd_out_d = rd_in;
      end else begin
        state_d = CALC;
      end
    end
    // an aborted operation must never publish a result
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign stall_req = reset && ((accept && !early) || state_q == CALC || state_q == FIX);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed table-driven bench for muldiv_unit at UNROLL 1 and 4
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd_in = '0;
  logic        stall1, busy1, done1, stall4, busy4, done4;
  logic [31:0] res1, res4;
  logic [4:0]  rdo1, rdo4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .start(start1), .op(op), .a(a), .b(b),
    .rd_in(rd_in), .stall_req(stall1), .busy(busy1), .done(done1), .result(res1), .rd_out(rdo1)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
    .clk(clk), .reset(reset), .flush(flush), .start(start4), .op(op), .a(a), .b(b),
    .rd_in(rd_in), .stall_req(stall4), .busy(busy4), .done(done4), .result(res4), .rd_out(rdo4)
  );

  typedef struct {
    bit          u4;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
    int          stalls;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // cycle k is sampled at negedge+1; the start edge closes cycle 0
  task automatic run_vec(input int idx, input vec_t v);
    int lat, stalls, dones;
    logic [31:0] r;
    logic [4:0] ro;
    lat = -1; stalls = 0; dones = 0; r = '0; ro = '0;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; rd_in = v.rd;
    if (v.u4) start4 = 1'b1; else start1 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        start1 = 1'b0; start4 = 1'b0;
        op = ~v.op; a = ~v.a; b = v.b + 32'd3; rd_in = ~v.rd;
      end
      #1;
      if (v.u4 ? stall4 : stall1) stalls++;
      if (v.u4 ? done4 : done1) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          r = v.u4 ? res4 : res1;
          ro = v.u4 ? rdo4 : rdo1;
        end
      end
    end
    check($sformatf("vec%0d result", idx), r, v.res);
    check($sformatf("vec%0d rd_out", idx), {27'd0, ro}, {27'd0, v.rd});
    check($sformatf("vec%0d done_cycle", idx), lat, v.lat);
    check($sformatf("vec%0d stall_cycles", idx), stalls, v.stalls);
    check($sformatf("vec%0d done_pulses", idx), dones, 1);
    check($sformatf("vec%0d busy_after", idx), {31'd0, v.u4 ? busy4 : busy1}, 0);
  endtask

  task automatic abort_seq(input bit use_reset);
    logic [31:0] prev_r;
    logic [4:0] prev_rd;
    int dones, first;
    logic [31:0] r;
    logic [4:0] ro;
    dones = 0; first = -1; r = '0; ro = '0;
    @(negedge clk);
    prev_r = res1; prev_rd = rdo1;
    op = 3'd0; a = 32'd3; b = 32'd5; rd_in = 5'd9; start1 = 1'b1;
    for (int k = 0; k < 52; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (k == 10) begin
        if (use_reset) reset = 1'b0; else flush = 1'b1;
      end
      if (k == 11) begin
        reset = 1'b1; flush = 1'b0;
        op = 3'd0; a = 32'd4; b = 32'd6; rd_in = 5'd12; start1 = 1'b1;
      end
      if (k == 12) start1 = 1'b0;
      #1;
      if (k == 10 && use_reset) check("reset_low stall", {31'd0, stall1}, 0);
      if (k == 11) begin
        check(use_reset ? "reset_abort busy" : "flush busy", {31'd0, busy1}, 0);
        check(use_reset ? "reset_abort result" : "flush result", res1, use_reset ? 32'd0 : prev_r);
        check(use_reset ? "reset_abort rd_out" : "flush rd_out", {27'd0, rdo1},
              use_reset ? 32'd0 : {27'd0, prev_rd});
      end
      if (done1) begin
        dones++;
        if (first < 0) begin first = k; r = res1; ro = rdo1; end
      end
    end
    check(use_reset ? "reset_restart done_cycle" : "flush_restart done_cycle", first, 45);
    check(use_reset ? "reset_restart pulses" : "flush_restart pulses", dones, 1);
    check(use_reset ? "reset_restart result" : "flush_restart result", r, 32'd24);
    check(use_reset ? "reset_restart rd_out" : "flush_restart rd_out", {27'd0, ro}, 32'd12);
  endtask

  task automatic back_to_back;
    int dones, d0, d1;
    logic [31:0] r0, r1;
    logic [4:0] ro0, ro1;
    dones = 0; d0 = -1; d1 = -1; r0 = '0; r1 = '0; ro0 = '0; ro1 = '0;
    @(negedge clk);
    op = 3'd0; a = 32'd6; b = 32'd7; rd_in = 5'd3; start1 = 1'b1;
    for (int k = 0; k < 72; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (k == 5) begin op = 3'd0; a = 32'd2; b = 32'd2; rd_in = 5'd7; start1 = 1'b1; end
      if (k == 6) start1 = 1'b0;
      if (k == 34) begin op = 3'd0; a = 32'd9; b = 32'd9; rd_in = 5'd4; start1 = 1'b1; end
      if (k == 35) start1 = 1'b0;
      #1;
      if (k == 35) check("b2b busy_no_gap", {31'd0, busy1}, 1);
      if (done1) begin
        dones++;
        if (d0 < 0) begin d0 = k; r0 = res1; ro0 = rdo1; end
        else if (d1 < 0) begin d1 = k; r1 = res1; ro1 = rdo1; end
      end
    end
    check("b2b first done_cycle", d0, 34);
    check("b2b first result", r0, 32'd42);
    check("b2b first rd_out", {27'd0, ro0}, 32'd3);
    check("b2b second done_cycle", d1, 68);
    check("b2b second result", r1, 32'd81);
    check("b2b second rd_out", {27'd0, ro1}, 32'd4);
    check("b2b pulses", dones, 2);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34, 34};
    vecs[1]  = '{1'b0, 3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 34, 34};
    vecs[2]  = '{1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34, 34};
    vecs[3]  = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 34, 34};
    vecs[4]  = '{1'b1, 3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 10, 10};
    vecs[5]  = '{1'b1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 10, 10};
    vecs[6]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 10, 10};
    vecs[7]  = '{1'b0, 3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFD, 34, 34};
    vecs[8]  = '{1'b0, 3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFF, 34, 34};
    vecs[9]  = '{1'b0, 3'd5, 32'd100,      32'd7,        5'd10, 32'h0000000E, 34, 34};
    vecs[10] = '{1'b0, 3'd7, 32'd100,      32'd7,        5'd11, 32'h00000002, 34, 34};
    vecs[11] = '{1'b0, 3'd4, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1, 0};
    vecs[12] = '{1'b0, 3'd7, 32'd5,        32'd0,        5'd13, 32'h00000005, 1, 0};
    vecs[13] = '{1'b0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1, 0};
    vecs[14] = '{1'b0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1, 0};
    vecs[15] = '{1'b0, 3'd4, 32'd20,       32'hFFFFFFFD, 5'd16, 32'hFFFFFFFA, 34, 34};
    vecs[16] = '{1'b0, 3'd6, 32'd20,       32'hFFFFFFFD, 5'd17, 32'h00000002, 34, 34};
    vecs[17] = '{1'b0, 3'd6, 32'hFFFFFFEC, 32'd3,        5'd18, 32'hFFFFFFFE, 34, 34};
    vecs[18] = '{1'b1, 3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd19, 32'hFFFFFFFD, 10, 10};
    vecs[19] = '{1'b1, 3'd0, 32'h12345678, 32'h00000010, 5'd20, 32'h23456780, 10, 10};
    vecs[20] = '{1'b0, 3'd1, 32'hFFFFFFFF, 32'h00000003, 5'd21, 32'hFFFFFFFF, 34, 34};
    vecs[21] = '{1'b0, 3'd3, 32'h00010000, 32'h00010000, 5'd22, 32'h00000001, 34, 34};
    vecs[22] = '{1'b0, 3'd5, 32'd5,        32'd0,        5'd23, 32'hFFFFFFFF, 1, 0};
    vecs[23] = '{1'b1, 3'd6, 32'd5,        32'd0,        5'd24, 32'h00000005, 1, 0};

    // start is held high during reset and must be ignored
    @(negedge clk);
    op = 3'd0; a = 32'd1; b = 32'd1; rd_in = 5'd1; start1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall_req", {31'd0, stall1}, 0);
    check("reset busy", {31'd0, busy1}, 0);
    check("reset done", {31'd0, done1}, 0);
    check("reset result", res1, 32'd0);
    check("reset rd_out", {27'd0, rdo1}, 32'd0);
    @(negedge clk);
    start1 = 1'b0; reset = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset busy", {31'd0, busy1}, 0);
    check("post_reset busy4", {31'd0, busy4}, 0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    abort_seq(1'b0);
    abort_seq(1'b1);
    back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
